// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: redirect sources and
// default vector constants.
package pc_pkg;

    // Source of the update applied to the program counter in a cycle.
    typedef enum logic [2:0] {
        SEQ,
        CALL,
        RET,
        RETI,
        BRANCH,
        IRQ
    } redirect_src_e;

    localparam int unsigned PC_DEF_AW        = 10;
    localparam int unsigned PC_DEF_RAS_DEPTH = 8;
    localparam int unsigned PC_DEF_RESET_VEC = 0;

    // Default interrupt entry: four words below the top of the address space.
    function automatic int unsigned pc_def_irq_vec(input int unsigned aw);
        return (32'd1 << aw) - 32'd4;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty leaves the stack untouched. Over/underflow flags
// are sticky until clr_err (a same-cycle set wins).
// Ports: clk, reset (async, active-high), push/pop/push_data requests,
//        clr_err; top_c (combinational top entry), count, full, empty,
//        ovf, unf (registered).
module ras_stack #(
    parameter int unsigned AW        = 10,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [AW-1:0]                      push_data,
    input  logic                               clr_err,
    output logic [AW-1:0]                      top_c,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     count,
    output logic                               full,
    output logic                               empty,
    output logic                               ovf,
    output logic                               unf
);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [AW-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0] r_sp;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf;
    logic          r_unf;

    logic [PW-1:0] w_sp_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic [PW-1:0] w_top_idx;

    // Next pointer/count; push and pop are mutually exclusive at the caller.
    always_comb begin
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (push) begin
            w_sp_nxt = r_sp + PW'(1);
            if (r_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_count_nxt = r_count + CW'(1);
            end
        end else if (pop) begin
            if (r_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_sp_nxt    = r_sp - PW'(1);
                w_count_nxt = r_count - CW'(1);
            end
        end
    end

    // Storage carries no reset; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_sp] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_sp    <= w_sp_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(RAS_DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf   <= w_unf_set | (r_unf & ~clr_err);
        end
    end

    always_comb w_top_idx = r_sp - PW'(1);

    assign top_c = r_mem[w_top_idx];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack and single-level interrupt.
// Priority per cycle: irq (when not in_irq) > branch > reti > ret > call >
// sequential; stall only holds the sequential increment.
// Ports: clk, reset (async, active-high); stall, branch/branch_address,
//        call/call_target, ret, irq, reti, clr_err inputs; pc_out,
//        ras_count, ras_empty, ras_full, ras_ovf, ras_unf, in_irq,
//        redirect outputs (all registered).
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int unsigned   AW        = PC_DEF_AW,
    parameter int unsigned   RAS_DEPTH = PC_DEF_RAS_DEPTH,
    parameter logic [AW-1:0] RESET_VEC = AW'(PC_DEF_RESET_VEC),
    parameter logic [AW-1:0] IRQ_VEC   = AW'(pc_def_irq_vec(AW))
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           branch,
    input  logic [AW-1:0]                  branch_address,
    input  logic                           call,
    input  logic [AW-1:0]                  call_target,
    input  logic                           ret,
    input  logic                           irq,
    input  logic                           reti,
    input  logic                           clr_err,
    output logic [AW-1:0]                  pc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_ovf,
    output logic                           ras_unf,
    output logic                           in_irq,
    output logic                           redirect
);
    logic [AW-1:0]  r_pc;
    logic           r_in_irq;
    logic           r_redirect;

    redirect_src_e  w_src;
    logic [AW-1:0]  w_pc_inc;
    logic [AW-1:0]  w_pc_nxt;
    logic           w_in_irq_nxt;
    logic           w_push;
    logic           w_pop;
    logic [AW-1:0]  w_push_data;
    logic [AW-1:0]  w_top;

    // Select the single winning request; everything else is dropped.
    always_comb begin
        w_src = SEQ;
        if (irq && !r_in_irq) begin
            w_src = IRQ;
        end else if (branch) begin
            w_src = BRANCH;
        end else if (reti) begin
            w_src = RETI;
        end else if (ret) begin
            w_src = RET;
        end else if (call) begin
            w_src = CALL;
        end
    end

    always_comb w_pc_inc = r_pc + AW'(1);

    // Next PC, interrupt state and stack request for the winning source.
    always_comb begin
        w_pc_nxt     = r_pc;
        w_in_irq_nxt = r_in_irq;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_push_data  = w_pc_inc;
        case (w_src)
            IRQ: begin
                w_push       = 1'b1;
                w_push_data  = r_pc;
                w_pc_nxt     = IRQ_VEC;
                w_in_irq_nxt = 1'b1;
            end
            BRANCH: w_pc_nxt = branch_address;
            RETI, RET: begin
                w_pop    = 1'b1;
                // Underflow falls through to the next sequential address.
                w_pc_nxt = ras_empty ? w_pc_inc : w_top;
                if (w_src == RETI) begin
                    w_in_irq_nxt = 1'b0;
                end
            end
            CALL: begin
                w_push   = 1'b1;
                w_pc_nxt = call_target;
            end
            default: begin
                if (!stall) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_VEC;
            r_in_irq   <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_in_irq   <= w_in_irq_nxt;
            r_redirect <= (w_src != SEQ);
        end
    end

    ras_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .clr_err   (clr_err),
        .top_c     (w_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    assign pc_out   = r_pc;
    assign in_irq   = r_in_irq;
    assign redirect = r_redirect;

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter AW, default 10: address width.
REQ-002 SHALL have parameter RAS_DEPTH, default 8 (power of two, >=2): return-address stack entries.
REQ-003 SHALL have parameter RESET_VEC, default 0: pc_out value after reset.
REQ-004 SHALL have parameter IRQ_VEC, default 2^AW-4: interrupt entry address.
REQ-005 SHALL have port clk  in  1  clock, rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port stall  in  1  hold the sequential increment.
REQ-008 SHALL have port branch  in  1  jump to branch_address.
REQ-009 SHALL have port branch_address  in  AW  jump target.
REQ-010 SHALL have port call  in  1  push pc_out+1 and jump to call_target.
REQ-011 SHALL have port call_target  in  AW  subroutine entry.
REQ-012 SHALL have port ret  in  1  pop the stack into pc_out.
REQ-013 SHALL have port irq  in  1  level interrupt request.
REQ-014 SHALL have port reti  in  1  return from interrupt: pop the stack and clear in_irq.
REQ-015 SHALL have port clr_err  in  1  clear sticky error flags.
REQ-016 SHALL have port pc_out  out  AW  current program counter, registered.
REQ-017 SHALL have port ras_count  out  clog2(RAS_DEPTH+1)  valid stack entries.
REQ-018 SHALL have port ras_empty / ras_full  out  1 each  count==0 / count==RAS_DEPTH.
REQ-019 SHALL have port ras_ovf / ras_unf  out  1 each  sticky overflow / underflow.
REQ-020 SHALL have port in_irq  out  1  interrupt handler active.
REQ-021 SHALL have port redirect  out  1  registered one-cycle pulse: the last update was non-sequential.

Function
REQ-022 SHALL update once per rising clk with priority irq (only when in_irq=0) > branch > reti > ret > call > sequential.
REQ-023 SHALL act only on the highest-priority request in a cycle; lower-priority requests are dropped with no push, pop, or flag change.
REQ-024 SHALL let every redirect (irq, branch, reti, ret, call) take effect regardless of stall; stall gates only the sequential case.
REQ-025 SHALL perform the sequential case as pc_out <= pc_out+1 modulo 2^AW when stall=0, and hold pc_out when stall=1.
REQ-026 SHALL on call: push (pc_out+1) mod 2^AW, then set pc_out <= call_target.
REQ-027 SHALL on irq accept: push pc_out (resume address), set pc_out <= IRQ_VEC, and set in_irq=1.
REQ-028 SHALL ignore irq while in_irq=1 (no nesting).
REQ-029 SHALL on ret or reti with count>0: set pc_out <= top entry and decrement count; reti also clears in_irq.
REQ-030 SHALL on ret or reti with count==0: set pc_out <= pc_out+1, set ras_unf, leave count at 0, and still clear in_irq on reti.
REQ-031 SHALL implement the stack as circular: a push at count==RAS_DEPTH overwrites the oldest entry, keeps count saturated, and sets ras_ovf.
REQ-032 SHALL keep ras_ovf and ras_unf set until clr_err or reset; a same-cycle set has priority over clr_err.
REQ-033 SHALL drive redirect=1 in the cycle after any redirect, else 0.
REQ-034 SHALL register all outputs; pc_out changes only at clk edges or on reset.

Reset
REQ-035 SHALL on reset assert asynchronously set pc_out=RESET_VEC, count/pointers=0, ras_empty=1, ras_full=0, ras_ovf=ras_unf=in_irq=redirect=0.
REQ-036 SHALL on reset during an active call/ret or irq discard that operation; stack contents after reset are don't-care.

Structure
REQ-037 SHALL take the redirect-source enum (SEQ, CALL, RET, RETI, BRANCH, IRQ) and default vector constants from shared package pc_pkg.
REQ-038 SHALL instantiate one sub-module ras_stack (parameters AW, RAS_DEPTH; push/pop/data ports; count, full/empty, overflow/underflow outputs).

Verification
REQ-039 Reset, then 3 cycles with stall=0 -> pc_out 0,1,2,3; stall=1 for 2 cycles -> pc_out holds at 3.
REQ-040 pc_out=5, call with call_target=0x40 -> pc_out=0x40, count=1; then ret -> pc_out=6, count=0, redirect pulses each time.
REQ-041 RAS_DEPTH=8: 9 nested calls -> ras_full=1, ras_ovf=1, count=8; 8 rets return the 8 newest addresses; 9th ret -> ras_unf=1, pc_out=prev+1.
REQ-042 irq with branch in the same cycle at pc_out=0x10 -> pc_out=IRQ_VEC, in_irq=1, 0x10 pushed; second irq ignored; reti -> pc_out=0x10, in_irq=0.
REQ-043 pc_out=2^AW-1, stall=0 -> pc_out=0; branch while stall=1 -> pc_out=branch_address; reset asserted mid-call -> pc_out=RESET_VEC, count=0 immediately.
